ifetch_queue: RTL and testbench

Instruction-fetch front end for the RV32I pipeline. It issues word fetches to the instruction memory port and follows a sequential or predicted PC. Each returned word is buffered, together with its PC, PC+4 and next-PC prediction, in a small FIFO of `fetch_ex_pipeline_reg_t` entries. The execute stage consumes the FIFO head; a redirect from execute flushes the queue and restarts fetch.

---
 rtl/ifetch_queue.sv | 128 ++++++++++++
 tb/tb_ifetch_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// RV32I instruction-fetch front end: issues word fetches and buffers PC/PC+4/prediction/instr entries.
// Optional same-cycle bypass of an empty queue is enabled by defining IFETCH_BYPASS_EN.
`timescale 1ns/1ps

package ifetch_pkg;
  typedef struct packed {
    logic        token;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] prediction;
  } fetch_ex_pipeline_reg_t;
endpackage

module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  output logic                   imem_ren,
  output logic [31:0]            imem_addr,
  input  logic                   imem_busy,
  input  logic [31:0]            imem_rdata,
  input  logic                   predict_taken,
  input  logic [31:0]            predict_target,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   ex_ready,
  output fetch_ex_pipeline_reg_t fetch_ex_reg
);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [0:0] FETCH   = 1'b0;
  localparam logic [0:0] DISCARD = 1'b1;

  logic [0:0]             state;
  logic [31:0]            req_addr;
  logic [31:0]            fetch_pc;
  fetch_ex_pipeline_reg_t mem [DEPTH];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [PW:0]            count;

  logic                   empty;
  logic                   done;
  logic                   push;
  logic                   pop;
  logic                   bypass_take;
  logic [31:0]            redirect_addr;
  logic [31:0]            pc4;
  logic [31:0]            prediction;
  fetch_ex_pipeline_reg_t new_entry;

  assign empty         = (count == '0);
  // count never exceeds DEPTH (a power of two), so its top bit alone means "full"
  assign imem_ren      = nRST && ((state == DISCARD) || !count[PW]);
  assign imem_addr     = req_addr;
  assign done          = imem_ren && !imem_busy;
  assign redirect_addr = redirect_pc & 32'hFFFF_FFFC;
  assign pc4           = req_addr + 32'd4;
  assign prediction    = predict_taken ? (predict_target & 32'hFFFF_FFFC) : pc4;

  always_comb begin
    new_entry            = '0;
    new_entry.token      = 1'b1;
    new_entry.pc         = req_addr;
    new_entry.pc4        = pc4;
    new_entry.instr      = imem_rdata;
    new_entry.prediction = prediction;
  end

`ifdef IFETCH_BYPASS_EN
  logic bypass;
  assign bypass       = empty && (state == FETCH) && done && !redirect;
  assign bypass_take  = bypass && ex_ready;
  assign fetch_ex_reg = bypass ? new_entry : (empty ? '0 : mem[rd_ptr]);
`else
  assign bypass_take  = 1'b0;
  assign fetch_ex_reg = empty ? '0 : mem[rd_ptr];
`endif

  assign push = (state == FETCH) && done && !redirect && !bypass_take;
  assign pop  = !empty && ex_ready && !redirect;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= FETCH;
      req_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= redirect_addr;
      // an in-flight request must finish on its old address before the restart is issued
      if (imem_ren && imem_busy) begin
        state <= DISCARD;
      end else begin
        state    <= FETCH;
        req_addr <= redirect_addr;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (done) begin
        if (state == DISCARD) begin
          state    <= FETCH;
          req_addr <= fetch_pc;
        end else begin
          req_addr <= prediction;
          fetch_pc <= prediction;
        end
      end
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a PC-stream model predicts every consumed entry.
`timescale 1ns/1ps

module tb_ifetch_queue;
  import ifetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0200;

  logic                   CLK = 1'b0;
  logic                   nRST = 1'b0;
  logic                   imem_ren;
  logic [31:0]            imem_addr;
  logic                   imem_busy = 1'b0;
  logic [31:0]            imem_rdata;
  logic                   predict_taken;
  logic [31:0]            predict_target;
  logic                   redirect = 1'b0;
  logic [31:0]            redirect_pc = '0;
  logic                   ex_ready = 1'b0;
  fetch_ex_pipeline_reg_t fetch_ex_reg;

  always #5 CLK = ~CLK;

  ifetch_queue #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_busy(imem_busy), .imem_rdata(imem_rdata),
    .predict_taken(predict_taken), .predict_target(predict_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ex_ready(ex_ready), .fetch_ex_reg(fetch_ex_reg)
  );

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned consumed = 0;
  int          pred_mode = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic p_taken(input int mode, input logic [31:0] a);
    case (mode)
      1:       return a == 32'h0000_0204;
      2:       return a[5:2] == 4'b1011;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] p_target(input int mode, input logic [31:0] a);
    if (mode == 1) return 32'h0000_1000;
    return {16'h0000, a[15:0] ^ 16'h2A5B};
  endfunction

  always_comb begin
    imem_rdata     = mem_word(imem_addr);
    predict_taken  = p_taken(pred_mode, imem_addr);
    predict_target = p_target(pred_mode, imem_addr);
  end

  // Reference model: the consumed stream follows pc -> prediction, restarting on reset/redirect.
  fetch_ex_pipeline_reg_t exp_q[$];
  logic [31:0]            model_pc;

  task automatic refill();
    fetch_ex_pipeline_reg_t e;
    while (exp_q.size() < 4) begin
      e.token      = 1'b1;
      e.pc         = model_pc;
      e.pc4        = model_pc + 32'd4;
      e.instr      = mem_word(model_pc);
      e.prediction = p_taken(pred_mode, model_pc) ? (p_target(pred_mode, model_pc) & 32'hFFFF_FFFC)
                                                  : model_pc + 32'd4;
      exp_q.push_back(e);
      model_pc = e.prediction;
    end
  endtask

  task automatic restart(input logic [31:0] a);
    exp_q.delete();
    model_pc = a & 32'hFFFF_FFFC;
    refill();
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Monitor: protocol checks plus scoreboard compare on every consumed head.
  logic                   prev_hold = 1'b0;
  logic [31:0]            prev_addr = '0;
  fetch_ex_pipeline_reg_t mon_exp;

  always @(negedge CLK) begin
    if (!nRST) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check1("hold_ren", imem_ren, 1'b1);
        check32("hold_addr", imem_addr, prev_addr);
      end
      check32("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
      prev_hold = imem_ren && imem_busy;
      prev_addr = imem_addr;
      if (fetch_ex_reg.token && ex_ready && !redirect) begin
        refill();
        mon_exp = exp_q.pop_front();
        consumed++;
        checks++;
        if (fetch_ex_reg === mon_exp) passed++;
        else $display("FAIL entry: got pc=%h pc4=%h instr=%h pred=%h expected pc=%h pc4=%h instr=%h pred=%h",
                      fetch_ex_reg.pc, fetch_ex_reg.pc4, fetch_ex_reg.instr, fetch_ex_reg.prediction,
                      mon_exp.pc, mon_exp.pc4, mon_exp.instr, mon_exp.prediction);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic neg();
    @(negedge CLK);
  endtask

  // Leaves the bench at the drive point of cycle 0 (first cycle with nRST high).
  task automatic do_reset(input int mode);
    nRST      = 1'b0;
    redirect  = 1'b0;
    imem_busy = 1'b0;
    pred_mode = mode;
    restart(RST_PC);
    neg();
    check1("rst_ren", imem_ren, 1'b0);
    check32("rst_addr", imem_addr, RST_PC);
    check1("rst_head_zero", fetch_ex_reg == '0, 1'b1);
    cyc();
    nRST = 1'b1;
  endtask

  int unsigned start_consumed;

  initial begin
    cyc();

    // Sequential stream with a taken prediction at 0x204.
    ex_ready = 1'b1;
    do_reset(1);
    neg();
    check1("first_ren", imem_ren, 1'b1);
    check32("first_addr", imem_addr, RST_PC);
`ifdef IFETCH_BYPASS_EN
    check1("bypass_token", fetch_ex_reg.token, 1'b1);
`else
    check1("queued_token", fetch_ex_reg.token, 1'b0);
`endif
    cyc(); neg();
    check32("seq_addr", imem_addr, 32'h0000_0204);
    check1("seq_token", fetch_ex_reg.token, 1'b1);
    cyc(); neg();
    check32("pred_addr", imem_addr, 32'h0000_1000);
    repeat (8) cyc();

    // Fill to DEPTH with execute stalled, then release one entry.
    ex_ready = 1'b0;
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      neg();
      check1("fill_ren", imem_ren, 1'b1);
      cyc();
    end
    neg();
    check1("full_ren", imem_ren, 1'b0);
    check32("full_head", fetch_ex_reg.pc, RST_PC);
    cyc();
    ex_ready = 1'b1;
    neg();
    check1("full_ren_pop", imem_ren, 1'b0);
    cyc();
    ex_ready = 1'b0;
    neg();
    check1("refill_ren", imem_ren, 1'b1);
    check32("refill_addr", imem_addr, 32'h0000_0210);
    cyc();
    ex_ready = 1'b1;
    repeat (10) cyc();

    // Redirect while the request on 0x208 is stalled.
    do_reset(0);
    cyc();
    cyc();
    imem_busy   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3002;
    restart(redirect_pc);
    neg();
    check32("busy_addr", imem_addr, 32'h0000_0208);
    cyc();
    redirect = 1'b0;
    neg();
    check1("rd_token", fetch_ex_reg.token, 1'b0);
    check32("rd_hold", imem_addr, 32'h0000_0208);
    cyc();
    imem_busy = 1'b0;
    neg();
    check1("discard_token", fetch_ex_reg.token, 1'b0);
    cyc(); neg();
    check1("rd_new_ren", imem_ren, 1'b1);
    check32("rd_new_addr", imem_addr, 32'h0000_3000);
    repeat (10) cyc();

    // Redirect coincident with push and pop on a nearly full queue.
    ex_ready = 1'b0;
    do_reset(0);
    repeat (4) cyc();
    ex_ready = 1'b1;
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_5002;
    restart(redirect_pc);
    neg();
    check1("coinc_ren", imem_ren, 1'b1);
    check1("coinc_token", fetch_ex_reg.token, 1'b1);
    cyc();
    redirect = 1'b0;
    ex_ready = 1'b0;
    neg();
    check1("flush_token", fetch_ex_reg.token, 1'b0);
    check32("flush_addr", imem_addr, 32'h0000_5000);
    repeat (4) cyc();
    neg();
    check1("flush_count", imem_ren, 1'b0);
    cyc();
    ex_ready = 1'b1;
    repeat (10) cyc();

    // Randomised traffic: wait states, stalls, redirects, taken predictions, PC wrap.
    do_reset(2);
    start_consumed = consumed;
    for (int i = 0; i < 4000; i++) begin
      int unsigned r;
      imem_busy = ($urandom_range(0, 9) < 3);
      ex_ready  = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 99);
      if (r < 3) begin
        redirect    = 1'b1;
        redirect_pc = (r == 0) ? 32'hFFFF_FFF9 : ($urandom & 32'h0000_FFFF);
        restart(redirect_pc);
      end else begin
        redirect = 1'b0;
      end
      cyc();
    end
    redirect = 1'b0;
    neg();
    check1("progress", (consumed - start_consumed) >= 500, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
